fft_dual_bank_mem: RTL and testbench

FFT_DUAL_BANK_MEM -- requirements
Module: fft_dual_bank_mem

---
 rtl/fft_dual_bank_mem.sv | 216 +++++++++++++++++++++
 tb/tb_fft_dual_bank_mem.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_dual_bank_mem.sv
// Two-bank ping-pong style FFT working memory: butterfly pairs land in opposite banks,
// so each cycle can serve one paired read and one paired write. Includes a zero-fill sweep.
module fft_dual_bank_mem #(
    parameter int LENGTH  = 32,
    parameter int R       = 5,
    parameter int OUT_REG = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    output logic                  o_busy,
    input  logic                  i_rd_en,
    input  logic [R-1:0]          i_rd_addr0,
    input  logic [R-1:0]          i_rd_addr1,
    output logic [2*LENGTH-1:0]   o_rd_data0,
    output logic [2*LENGTH-1:0]   o_rd_data1,
    output logic                  o_rd_valid,
    input  logic                  i_wr_en,
    input  logic [R-1:0]          i_wr_addr0,
    input  logic [R-1:0]          i_wr_addr1,
    input  logic [2*LENGTH-1:0]   i_wr_data0,
    input  logic [2*LENGTH-1:0]   i_wr_data1,
    output logic                  o_conflict
);

    localparam int W    = 2 * LENGTH;
    localparam int RW   = R - 1;
    localparam int ROWS = 2 ** RW;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [RW-1:0]  row_cnt_reg;
    logic           busy;
    logic           sweep_we;
    logic           sweep_start;
    logic           sweep_done;

    logic           rd_acc;
    logic           wr_acc;
    logic           rd_par0;
    logic           rd_par1;
    logic           wr_par0;
    logic           wr_par1;
    logic           rd_conf;
    logic           wr_conf;

    logic           sel_reg;
    logic           rd_conf_reg;
    logic           valid_reg;
    logic           conflict_reg;
    logic [W-1:0]   data0_s;
    logic [W-1:0]   data1_s;

    assign sweep_start = (state_reg == IDLE) && i_clr;
    assign sweep_done  = (row_cnt_reg == RW'(ROWS - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_clr)      state_next = CLEAR;
            CLEAR:   if (sweep_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        sweep_we = 1'b0;
        if (state_reg == CLEAR) begin
            busy     = 1'b1;
            sweep_we = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            row_cnt_reg <= '0;
        end else if (sweep_start) begin
            row_cnt_reg <= '0;
        end else if (state_reg == CLEAR) begin
            row_cnt_reg <= row_cnt_reg + RW'(1);
        end
    end

    // Requests are dropped outright while the sweep owns both banks.
    assign rd_acc  = i_rd_en && !busy;
    assign wr_acc  = i_wr_en && !busy;
    assign rd_par0 = ^i_rd_addr0;
    assign rd_par1 = ^i_rd_addr1;
    assign wr_par0 = ^i_wr_addr0;
    assign wr_par1 = ^i_wr_addr1;
    assign rd_conf = rd_acc && (rd_par0 == rd_par1);
    assign wr_conf = wr_acc && (wr_par0 == wr_par1);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            logic [W-1:0]  mem [ROWS];
            logic [RW-1:0] rd_row;
            logic [RW-1:0] wr_row;
            logic [W-1:0]  wr_data;
            logic          we;
            logic [W-1:0]  rd_q;

            assign rd_row = (rd_par0 == 1'(gi)) ? i_rd_addr0[R-1:1] : i_rd_addr1[R-1:1];

            // Port 0 always wins a bank; port 1 only gets the other bank when parities differ.
            always_comb begin
                we      = 1'b0;
                wr_row  = row_cnt_reg;
                wr_data = '0;
                if (sweep_we) begin
                    we = 1'b1;
                end else if (wr_acc) begin
                    if (wr_par0 == 1'(gi)) begin
                        we      = 1'b1;
                        wr_row  = i_wr_addr0[R-1:1];
                        wr_data = i_wr_data0;
                    end else if (!wr_conf) begin
                        we      = 1'b1;
                        wr_row  = i_wr_addr1[R-1:1];
                        wr_data = i_wr_data1;
                    end
                end
            end

            always_ff @(posedge i_clk) begin
                if (we) begin
                    mem[wr_row] <= wr_data;
                end
            end

            // Non-blocking write above makes a same-row read return the old word.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    rd_q <= '0;
                end else if (rd_acc) begin
                    rd_q <= mem[rd_row];
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sel_reg     <= 1'b0;
            rd_conf_reg <= 1'b0;
            valid_reg   <= 1'b0;
        end else begin
            valid_reg <= rd_acc;
            if (rd_acc) begin
                sel_reg     <= rd_par0;
                rd_conf_reg <= rd_conf;
            end
        end
    end

    assign data0_s = sel_reg ? g_bank[1].rd_q : g_bank[0].rd_q;
    assign data1_s = rd_conf_reg ? '0 : (sel_reg ? g_bank[0].rd_q : g_bank[1].rd_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            conflict_reg <= 1'b0;
        end else if (sweep_start) begin
            conflict_reg <= 1'b0;
        end else if (rd_conf || wr_conf) begin
            conflict_reg <= 1'b1;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [W-1:0] data0_reg;
            logic [W-1:0] data1_reg;
            logic         valid2_reg;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    data0_reg  <= '0;
                    data1_reg  <= '0;
                    valid2_reg <= 1'b0;
                end else begin
                    valid2_reg <= valid_reg;
                    if (valid_reg) begin
                        data0_reg <= data0_s;
                        data1_reg <= data1_s;
                    end
                end
            end

            assign o_rd_data0 = data0_reg;
            assign o_rd_data1 = data1_reg;
            assign o_rd_valid = valid2_reg;
        end else begin : g_out_direct
            assign o_rd_data0 = data0_s;
            assign o_rd_data1 = data1_s;
            assign o_rd_valid = valid_reg;
        end
    endgenerate

    assign o_busy     = busy;
    assign o_conflict = conflict_reg;

endmodule

// File: tb/tb_fft_dual_bank_mem.sv
// Drives one OUT_REG=0 and one OUT_REG=1 instance with identical stimulus and checks both
// against a logical-address memory model.
module tb_fft_dual_bank_mem;

    localparam int LENGTH = 32;
    localparam int R      = 5;
    localparam int W      = 2 * LENGTH;
    localparam int N      = 2 ** R;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_clr;
    logic         i_rd_en;
    logic [R-1:0] i_rd_addr0;
    logic [R-1:0] i_rd_addr1;
    logic         i_wr_en;
    logic [R-1:0] i_wr_addr0;
    logic [R-1:0] i_wr_addr1;
    logic [W-1:0] i_wr_data0;
    logic [W-1:0] i_wr_data1;

    logic         o0_busy, o0_rd_valid, o0_conflict;
    logic [W-1:0] o0_rd_data0, o0_rd_data1;
    logic         o1_busy, o1_rd_valid, o1_conflict;
    logic [W-1:0] o1_rd_data0, o1_rd_data1;

    always #5 i_clk = ~i_clk;

    fft_dual_bank_mem #(.LENGTH(LENGTH), .R(R), .OUT_REG(0)) dut0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(i_clr), .o_busy(o0_busy),
        .i_rd_en(i_rd_en), .i_rd_addr0(i_rd_addr0), .i_rd_addr1(i_rd_addr1),
        .o_rd_data0(o0_rd_data0), .o_rd_data1(o0_rd_data1), .o_rd_valid(o0_rd_valid),
        .i_wr_en(i_wr_en), .i_wr_addr0(i_wr_addr0), .i_wr_addr1(i_wr_addr1),
        .i_wr_data0(i_wr_data0), .i_wr_data1(i_wr_data1), .o_conflict(o0_conflict)
    );

    fft_dual_bank_mem #(.LENGTH(LENGTH), .R(R), .OUT_REG(1)) dut1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(i_clr), .o_busy(o1_busy),
        .i_rd_en(i_rd_en), .i_rd_addr0(i_rd_addr0), .i_rd_addr1(i_rd_addr1),
        .o_rd_data0(o1_rd_data0), .o_rd_data1(o1_rd_data1), .o_rd_valid(o1_rd_valid),
        .i_wr_en(i_wr_en), .i_wr_addr0(i_wr_addr0), .i_wr_addr1(i_wr_addr1),
        .i_wr_data0(i_wr_data0), .i_wr_data1(i_wr_data1), .o_conflict(o1_conflict)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference state: a flat word-per-address memory plus sweep progress.
    logic [W-1:0] mm [N];
    int           sweep_left = 0;
    int           sweep_row  = 0;
    bit           m_conf     = 1'b0;
    bit           e_v0 = 1'b0, e_v1 = 1'b0;
    logic [W-1:0] e_d00 = '0, e_d01 = '0, e_d10 = '0, e_d11 = '0;

    function automatic bit odd(logic [R-1:0] a);
        return ($countones(a) % 2) == 1;
    endfunction

    task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit busy_exp;
        busy_exp = (sweep_left > 0);
        chk("busy0", W'(o0_busy), W'(busy_exp));
        chk("busy1", W'(o1_busy), W'(busy_exp));
        chk("conflict0", W'(o0_conflict), W'(m_conf));
        chk("conflict1", W'(o1_conflict), W'(m_conf));
        chk("valid0", W'(o0_rd_valid), W'(e_v0));
        chk("valid1", W'(o1_rd_valid), W'(e_v1));
        chk("data0_lat1", o0_rd_data0, e_d00);
        chk("data1_lat1", o0_rd_data1, e_d01);
        chk("data0_lat2", o1_rd_data0, e_d10);
        chk("data1_lat2", o1_rd_data1, e_d11);
    endtask

    task automatic idle();
        i_clr   = 1'b0;
        i_rd_en = 1'b0;
        i_wr_en = 1'b0;
    endtask

    // One clock: apply the model to the inputs currently driven, then compare after the edge.
    task automatic cycle();
        bit           rv;
        bit           conf_set;
        logic [W-1:0] nd0, nd1;
        bit           pv;
        logic [W-1:0] pd0, pd1;
        rv = 1'b0;
        conf_set = 1'b0;
        nd0 = '0;
        nd1 = '0;
        pv  = e_v0;
        pd0 = e_d00;
        pd1 = e_d01;
        if (sweep_left > 0) begin
            mm[2*sweep_row]   = '0;
            mm[2*sweep_row+1] = '0;
            sweep_row++;
            sweep_left--;
        end else begin
            if (i_rd_en) begin
                rv  = 1'b1;
                nd0 = mm[i_rd_addr0];
                if (odd(i_rd_addr0) == odd(i_rd_addr1)) conf_set = 1'b1;
                else nd1 = mm[i_rd_addr1];
            end
            if (i_wr_en) begin
                mm[i_wr_addr0] = i_wr_data0;
                if (odd(i_wr_addr0) == odd(i_wr_addr1)) conf_set = 1'b1;
                else mm[i_wr_addr1] = i_wr_data1;
            end
            if (i_clr) begin
                sweep_left = N / 2;
                sweep_row  = 0;
                m_conf     = 1'b0;
            end else if (conf_set) begin
                m_conf = 1'b1;
            end
        end
        @(posedge i_clk);
        #1;
        cyc++;
        e_v0 = rv;
        if (rv) begin
            e_d00 = nd0;
            e_d01 = nd1;
        end
        e_v1  = pv;
        e_d10 = pd0;
        e_d11 = pd1;
        check_outputs();
    endtask

    task automatic async_reset();
        idle();
        #1;
        i_rst = 1'b1;
        #1;
        sweep_left = 0;
        m_conf = 1'b0;
        e_v0 = 1'b0; e_v1 = 1'b0;
        e_d00 = '0; e_d01 = '0; e_d10 = '0; e_d11 = '0;
        check_outputs();
        #1;
        i_rst = 1'b0;
    endtask

    task automatic rd(logic [R-1:0] a0, logic [R-1:0] a1);
        i_rd_en = 1'b1; i_rd_addr0 = a0; i_rd_addr1 = a1;
    endtask

    task automatic wr(logic [R-1:0] a0, logic [W-1:0] d0, logic [R-1:0] a1, logic [W-1:0] d1);
        i_wr_en = 1'b1; i_wr_addr0 = a0; i_wr_data0 = d0; i_wr_addr1 = a1; i_wr_data1 = d1;
    endtask

    task automatic read_all();
        for (int k = 0; k < N / 2; k++) begin
            rd(R'(2*k), R'(2*k+1));
            cycle();
        end
        idle();
        cycle();
        cycle();
    endtask

    task automatic sweep();
        idle();
        i_clr = 1'b1;
        cycle();
        i_clr = 1'b0;
        for (int k = 0; k < N / 2 + 1; k++) begin
            i_rd_en = 1'b1;
            i_wr_en = k[0];
            i_rd_addr0 = R'($urandom); i_rd_addr1 = R'($urandom);
            i_wr_addr0 = R'($urandom); i_wr_addr1 = R'($urandom);
            i_wr_data0 = {$urandom, $urandom}; i_wr_data1 = {$urandom, $urandom};
            if (k == N / 2) idle();
            cycle();
        end
        idle();
        cycle();
    endtask

    initial begin
        i_rst = 1'b1;
        idle();
        i_rd_addr0 = '0; i_rd_addr1 = '0;
        i_wr_addr0 = '0; i_wr_addr1 = '0;
        i_wr_data0 = '0; i_wr_data1 = '0;
        for (int a = 0; a < N; a++) mm[a] = 'x;
        repeat (2) @(posedge i_clk);
        #1;
        check_outputs();
        i_rst = 1'b0;

        // Initial zero fill, with reads and writes offered while busy.
        sweep();
        read_all();

        // Paired write then paired read.
        wr(5'd3, 64'h11112222_33334444, 5'd7, 64'hAAAA5555_0000FFFF);
        cycle();
        idle();
        rd(5'd3, 5'd7);
        cycle();
        idle();
        cycle();
        cycle();

        // Read-first collision on address 5, then re-read.
        rd(5'd5, 5'd4);
        wr(5'd5, 64'hDEADBEEF_CAFEF00D, 5'd4, 64'h01234567_89ABCDEF);
        cycle();
        idle();
        rd(5'd5, 5'd4);
        cycle();
        idle();
        cycle();
        cycle();

        // Equal-parity write then equal-parity read.
        wr(5'd3, 64'h33333333_33333333, 5'd5, 64'h55555555_55555555);
        cycle();
        idle();
        rd(5'd3, 5'd5);
        cycle();
        idle();
        cycle();
        cycle();

        // Clearing sweep drops the sticky conflict.
        sweep();
        read_all();

        // Back-to-back read stream starting at (0,1).
        for (int k = 0; k < 8; k++) begin
            rd(R'(k), R'(k ^ 1));
            cycle();
        end
        idle();
        cycle();
        cycle();

        // Randomised traffic with occasional sweeps.
        for (int k = 0; k < 250; k++) begin
            i_rd_en    = ($urandom % 3) != 0;
            i_wr_en    = ($urandom % 2) != 0;
            i_clr      = ($urandom % 50) == 0;
            i_rd_addr0 = R'($urandom); i_rd_addr1 = R'($urandom);
            i_wr_addr0 = R'($urandom); i_wr_addr1 = R'($urandom);
            i_wr_data0 = {$urandom, $urandom}; i_wr_data1 = {$urandom, $urandom};
            cycle();
        end
        idle();
        repeat (N / 2 + 2) cycle();
        read_all();

        // Fill everything, then reset in sweep cycle 6.
        for (int k = 0; k < N / 2; k++) begin
            wr(R'(2*k), {$urandom, $urandom}, R'(2*k+1), {$urandom, $urandom});
            cycle();
        end
        idle();
        i_clr = 1'b1;
        cycle();
        i_clr = 1'b0;
        repeat (6) cycle();
        async_reset();
        cycle();
        read_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
